// File: rtl/fp_mul_scheduler_if.sv
// Requester-side bus of the FP multiplier scheduler.
// Carries operand requests, grants and the response strobe/data.
interface fp_mul_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic [3:0]            rsp_flags;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid,
    output rsp_data, rsp_flags
  );
endinterface

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one pipelined FP multiplier.
// Ports: clk, rst (sync, active-high), hold, bus (requester
// side: req_valid/a/b, req_ready, rsp_valid/data/flags),
// mul_valid/mul_a/mul_b to the multiplier, mul_result/mul_flags
// back from it, idle. Optional macro FP_SCHED_PRIO_EN gives
// requester 0 fixed priority over the round-robin group.
module fp_mul_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  fp_mul_scheduler_if.slave bus,
  output logic        mul_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  input  logic [3:0]  mul_flags,
  output logic        idle
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]          ptr;
  logic [IW-1:0]          mul_idx;
  logic [MUL_LATENCY-1:0] tag_v;
  logic [IW-1:0]          tag_idx [MUL_LATENCY];

  logic [IW:0]   pick;
  logic          fire;
  logic          upd_ptr;
  logic [IW-1:0] gnt_idx;

  // Returns {found, index}; iterating backwards lets the
  // first valid requester at or after p overwrite the rest.
  function automatic logic [IW:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IW-1:0]      p
  );
    logic [IW:0] r;
    int          j;
    r = '0;
    for (int o = NUM_REQ - 1; o >= 0; o--) begin
      j = (int'(p) + o) % NUM_REQ;
      if (v[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

`ifdef FP_SCHED_PRIO_EN
  localparam logic [NUM_REQ-1:0] HI_MASK = ~NUM_REQ'(1);

  always_comb begin
    pick = '0;
    if (bus.req_valid[0])
      pick = {1'b1, IW'(0)};
    else
      pick = rr_pick(bus.req_valid & HI_MASK, ptr);
  end

  // Priority grants to requester 0 leave the pointer alone.
  assign upd_ptr = fire && (gnt_idx != '0);
`else
  always_comb begin
    pick = rr_pick(bus.req_valid, ptr);
  end

  assign upd_ptr = fire;
`endif

  assign fire    = pick[IW] && !hold && !rst;
  assign gnt_idx = pick[IW-1:0];

  always_comb begin
    bus.req_ready = '0;
    if (fire) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_idx   <= '0;
    end else begin
      mul_valid <= fire;
      if (fire) begin
        mul_a   <= bus.req_a[{gnt_idx, 5'b0} +: 32];
        mul_b   <= bus.req_b[{gnt_idx, 5'b0} +: 32];
        mul_idx <= gnt_idx;
      end
      if (upd_ptr) begin
        if (gnt_idx == IW'(NUM_REQ - 1))
          ptr <= '0;
        else
          ptr <= gnt_idx + 1'b1;
      end
    end
  end

  // Tag pipe trails mul_valid by one stage, so the last entry
  // lines up with the multiplier output MUL_LATENCY cycles on.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < MUL_LATENCY; i++)
        tag_idx[i] <= '0;
    end else begin
      tag_v[0]   <= mul_valid;
      tag_idx[0] <= mul_idx;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (tag_v[MUL_LATENCY-1] && !rst)
      bus.rsp_valid[tag_idx[MUL_LATENCY-1]] = 1'b1;
  end

  assign bus.rsp_data  = mul_result;
  assign bus.rsp_flags = mul_flags;

  assign idle = rst || !(mul_valid || (|tag_v));

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed self-checking bench for fp_mul_scheduler with a
// latency-4 FP multiplier model (normal operands only).
module tb_fp_mul_scheduler;

  localparam int N = 4;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        mul_valid;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_result;
  logic [3:0]  mul_flags;
  logic        idle;
  logic [3:0]  flags_drive;

  int tests = 0;
  int fails = 0;

  fp_mul_scheduler_if #(.NUM_REQ(N)) bus ();

  fp_mul_scheduler #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .bus        (bus),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_flags  (mul_flags),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [47:0] p;
    logic [9:0]  e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47])
      return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  logic [L-1:0] st_v;
  logic [31:0]  st_r [L];
  logic [3:0]   st_f [L];

  always @(posedge clk) begin
    if (rst) st_v <= '0;
    else     st_v <= {st_v[L-2:0], mul_valid};
    st_r[0] <= fmul(mul_a, mul_b);
    st_f[0] <= flags_drive;
    for (int i = 1; i < L; i++) begin
      st_r[i] <= st_r[i-1];
      st_f[i] <= st_f[i-1];
    end
  end

  assign mul_result = st_r[L-1];
  assign mul_flags  = st_v[L-1] ? st_f[L-1] : 4'b0;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [31:0] prod [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[32*i +: 32] = op_a[i];
      bus.req_b[32*i +: 32] = op_b[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold = 1'b0;
    bus.req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold = 1'b0;
    bus.req_valid = '1;
    step();
    step();
    tests++;
    if (bus.req_ready !== 4'b0) begin
      fails++;
      $display("FAIL rst_ready got=%b exp=0000", bus.req_ready);
    end
    tests++;
    if (mul_valid !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0) begin
      fails++;
      $display("FAIL rst_mul got v=%b a=%h b=%h exp 0",
               mul_valid, mul_a, mul_b);
    end
    tests++;
    if (bus.rsp_valid !== 4'b0 || idle !== 1'b1) begin
      fails++;
      $display("FAIL rst_rsp_idle got rsp=%b idle=%b exp 0000/1",
               bus.rsp_valid, idle);
    end
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req_a[31:0] = 32'h4000_0000;
    bus.req_b[31:0] = 32'h4040_0000;
    bus.req_valid = 4'b0001;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_ready got=%b exp=0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    tests++;
    if (mul_valid !== 1'b1 || mul_a !== 32'h4000_0000 ||
        mul_b !== 32'h4040_0000) begin
      fails++;
      $display("FAIL single_issue got v=%b a=%h b=%h", mul_valid, mul_a, mul_b);
    end
    for (int k = 1; k < 5; k++) begin
      tests++;
      if (bus.rsp_valid !== 4'b0) begin
        fails++;
        $display("FAIL single_early k=%0d got=%b exp=0000", k, bus.rsp_valid);
      end
      step();
    end
    tests++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'h40C0_0000) begin
      fails++;
      $display("FAIL single_rsp got=%b/%h exp=0001/40c00000",
               bus.rsp_valid, bus.rsp_data);
    end
    tests++;
    if (idle !== 1'b0) begin
      fails++;
      $display("FAIL single_busy got idle=%b exp=0", idle);
    end
    step();
    tests++;
    if (idle !== 1'b1 || bus.rsp_valid !== 4'b0 || mul_valid !== 1'b0 ||
        mul_a !== 32'h4000_0000) begin
      fails++;
      $display("FAIL single_after got idle=%b rsp=%b v=%b a=%h",
               idle, bus.rsp_valid, mul_valid, mul_a);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    load_ops();
    for (int c = 0; c < 14; c++) begin
      bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        e = 4'b0001 << (c % 4);
        tests++;
        if (bus.req_ready !== e) begin
          fails++;
          $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, e);
        end
      end
      step();
      if (c >= 4 && c < 12) begin
        e = 4'b0001 << ((c - 4) % 4);
        tests++;
        if (bus.rsp_valid !== e || bus.rsp_data !== prod[(c-4)%4]) begin
          fails++;
          $display("FAIL rr_rsp c=%0d got=%b/%h exp=%b/%h", c,
                   bus.rsp_valid, bus.rsp_data, e, prod[(c-4)%4]);
        end
      end else begin
        tests++;
        if (bus.rsp_valid !== 4'b0) begin
          fails++;
          $display("FAIL rr_quiet c=%0d got=%b exp=0000", c, bus.rsp_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req_a[31:0] = 32'h4040_0000;
    bus.req_b[31:0] = 32'h4040_0000;
    for (int c = 0; c < 9; c++) begin
      bus.req_valid = (c < 3) ? 4'b0001 : 4'b0000;
      #1;
      if (c < 3) begin
        tests++;
        if (bus.req_ready !== 4'b0001) begin
          fails++;
          $display("FAIL b2b_grant c=%0d got=%b exp=0001", c, bus.req_ready);
        end
      end
      step();
      tests++;
      if (c >= 4 && c < 7) begin
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'h4110_0000) begin
          fails++;
          $display("FAIL b2b_rsp c=%0d got=%b/%h exp=0001/41100000", c,
                   bus.rsp_valid, bus.rsp_data);
        end
      end else if (bus.rsp_valid !== 4'b0) begin
        fails++;
        $display("FAIL b2b_quiet c=%0d got=%b exp=0000", c, bus.rsp_valid);
      end
    end
    load_ops();
  endtask

  task automatic test_hold();
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      hold = (c >= 3);
      bus.req_valid = (c < 3) ? 4'b0111 : 4'b1111;
      #1;
      if (c >= 3) begin
        tests++;
        if (bus.req_ready !== 4'b0) begin
          fails++;
          $display("FAIL hold_ready c=%0d got=%b exp=0000", c, bus.req_ready);
        end
      end
      step();
      e = (c >= 4 && c < 7) ? (4'b0001 << (c - 4)) : 4'b0000;
      tests++;
      if (bus.rsp_valid !== e) begin
        fails++;
        $display("FAIL hold_rsp c=%0d got=%b exp=%b", c, bus.rsp_valid, e);
      end
      if (c >= 6) begin
        tests++;
        if (idle !== (c >= 7)) begin
          fails++;
          $display("FAIL hold_idle c=%0d got=%b exp=%b", c, idle, c >= 7);
        end
      end
    end
    hold = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = (c < 2) ? 4'b0011 : 4'b0000;
      step();
    end
    rst = 1'b1;
    #1;
    tests++;
    if (idle !== 1'b1 || bus.rsp_valid !== 4'b0 || bus.req_ready !== 4'b0) begin
      fails++;
      $display("FAIL mid_rst_during got idle=%b rsp=%b rdy=%b",
               idle, bus.rsp_valid, bus.req_ready);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.rsp_valid !== 4'b0) seen++;
      step();
    end
    tests++;
    if (seen !== 0 || idle !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst_drop got rsp_count=%0d idle=%b exp 0/1",
               seen, idle);
    end
    bus.req_valid = 4'b1111;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL mid_rst_ptr got=%b exp=0001", bus.req_ready);
    end
    bus.req_valid = '0;
    step();
    for (int c = 0; c < 6; c++) step();
  endtask

  task automatic test_flags();
    do_reset();
    flags_drive = 4'b0010;
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = '0;
    for (int k = 1; k < 5; k++) begin
      tests++;
      if (bus.rsp_flags !== 4'b0 || bus.rsp_valid !== 4'b0) begin
        fails++;
        $display("FAIL flags_early k=%0d got=%b/%b exp 0000/0000", k,
                 bus.rsp_valid, bus.rsp_flags);
      end
      step();
    end
    tests++;
    if (bus.rsp_valid !== 4'b1000 || bus.rsp_flags !== 4'b0010 ||
        bus.rsp_data !== prod[3]) begin
      fails++;
      $display("FAIL flags_rsp got=%b/%b/%h exp=1000/0010/%h",
               bus.rsp_valid, bus.rsp_flags, bus.rsp_data, prod[3]);
    end
    flags_drive = 4'b0;
    step();
  endtask

  task automatic test_prio();
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = (c < 4) ? 4'b0101 : 4'b0100;
`ifdef FP_SCHED_PRIO_EN
      e = (c < 4) ? 4'b0001 : 4'b0100;
`else
      e = (c < 4 && c % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
      #1;
      tests++;
      if (bus.req_ready !== e) begin
        fails++;
        $display("FAIL prio_grant c=%0d got=%b exp=%b", c, bus.req_ready, e);
      end
      step();
    end
    bus.req_valid = '0;
    for (int c = 0; c < 6; c++) step();
  endtask

  initial begin
    op_a[0] = 32'h4000_0000; op_b[0] = 32'h3F80_0000;
    op_a[1] = 32'h4000_0000; op_b[1] = 32'h4000_0000;
    op_a[2] = 32'h4000_0000; op_b[2] = 32'h4040_0000;
    op_a[3] = 32'h4000_0000; op_b[3] = 32'h4080_0000;
    prod[0] = 32'h4000_0000;
    prod[1] = 32'h4080_0000;
    prod[2] = 32'h40C0_0000;
    prod[3] = 32'h4100_0000;
    flags_drive = 4'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_flags();
    test_prio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_mul_scheduler.md
FP_MUL_SCHEDULER -- requirements
Module: fp_mul_scheduler

Interface
- REQ-001: Parameter NUM_REQ, default 4, is the number of requesters sharing one pipelined FP multiplier (range 2..8).
- REQ-002: Parameter MUL_LATENCY, default 4, is the number of cycles from mul_valid/mul_a/mul_b to the matching mul_result/mul_flags.
- REQ-003: Port clk, input, 1, is the single clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1, is the reset: synchronous, active-high.
- REQ-005: Port hold, input, 1; when high, no new grants are issued and in-flight operations continue to drain.
- REQ-006: Port req_valid, input, NUM_REQ, carries the per-requester operand-valid bits.
- REQ-007: Port req_a, input, NUM_REQ*32, carries the requester i operand A at bits [32i+31:32i].
- REQ-008: Port req_b, input, NUM_REQ*32, carries the requester i operand B, laid out as req_a.
- REQ-009: Port req_ready, output, NUM_REQ, is the one-hot-or-zero grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- REQ-010: Port mul_valid, output, 1, is the registered issue strobe to the multiplier.
- REQ-011: Ports mul_a and mul_b, output, 32 each, are the registered operands to the multiplier.
- REQ-012: Port mul_result, input, 32, is the product from the multiplier.
- REQ-013: Port mul_flags, input, 4, carries {overflow, underflow, inf, nan} from the multiplier.
- REQ-014: Port rsp_valid, output, NUM_REQ, is a one-hot-or-zero response strobe with no backpressure.
- REQ-015: Ports rsp_data, output, 32, and rsp_flags, output, 4, are mul_result and mul_flags passed through unregistered.
- REQ-016: Port idle, output, 1, is high when no operation is in flight and mul_valid is low.

Function
- REQ-017: req_ready shall be combinational from req_valid, hold, rst and the round-robin pointer, with at most one bit high per cycle.
- REQ-018: The round-robin search shall start at the pointer and wrap modulo NUM_REQ; the first requester with req_valid high is granted.
- REQ-019: After a grant to requester k, the pointer shall become (k+1) mod NUM_REQ; with no grant, the pointer holds.
- REQ-020: When hold=1 or rst=1, req_ready shall be all zero.
- REQ-021: On a handshake in cycle N, mul_valid=1 and the granted mul_a/mul_b shall be presented in cycle N+1; with no handshake, mul_valid=0 and mul_a/mul_b hold their values.
- REQ-022: A tag pipeline of MUL_LATENCY entries, each {valid, requester index}, shall advance every cycle in step with mul_valid; it never stalls.
- REQ-023: rsp_valid[k] shall be high in cycle N+1+MUL_LATENCY for a cycle-N handshake by requester k; the scheduler sustains throughput of one operation per cycle.
- REQ-024: Responses shall return in issue order; back-to-back grants to the same requester are permitted.
- REQ-025: Asserting hold mid-stream shall stop only new issue; all outstanding responses are still delivered, and idle rises once the tag pipe is empty.

Reset
- REQ-026: While rst=1, the pointer shall reset to 0, mul_valid to 0, mul_a/mul_b to 0, all tag entries to invalid, rsp_valid to 0 and idle to 1.
- REQ-027: A reset asserted mid-operation shall discard in-flight operations, which produce no rsp_valid after reset.

Configuration
- REQ-028: With FP_SCHED_PRIO_EN defined, requester 0 shall win whenever req_valid[0]=1; otherwise round-robin applies among requesters 1..NUM_REQ-1, and the pointer updates only on those grants.
- REQ-029: Without FP_SCHED_PRIO_EN, all requesters shall be pure round-robin per REQ-018/019.

Verification
- REQ-030: After reset, req0 sends a=0x40000000, b=0x40400000 with a latency-4 multiplier model -> rsp_valid=4'b0001 and rsp_data=0x40C00000 exactly 5 cycles after the handshake.
- REQ-031: All four req_valid are held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with one grant per cycle and responses in the same order.
- REQ-032: hold=1 is raised with 3 operations in flight -> req_ready=0, 3 responses follow, then idle=1.
- REQ-033: rst is pulsed 2 cycles after 2 issues -> no rsp_valid afterwards, the pointer is 0 and idle=1.
- REQ-034: With FP_SCHED_PRIO_EN defined, req0 and req2 are held valid -> req0 is granted every cycle; when req0 drops, req2 is granted next.
- REQ-035: The model drives mul_flags=4'b0010 (inf) on a response -> rsp_flags=4'b0010 is seen in the same cycle as rsp_valid.
